// File: rtl/cpu_sequencer.sv
// Phase-based control sequencer for the RV32-subset core.
// Optional single-step input enabled by defining SEQ_STEP_EN.
module cpu_sequencer #(
  parameter int PC_W     = 5,
  parameter int PC_LAST  = 8,
  parameter int MEM_WAIT = 1
) (
  input  logic            CLOCK_50,
  input  logic            reset_n,
  input  logic            run,
`ifdef SEQ_STEP_EN
  input  logic            step,
`endif
  input  logic [6:0]      opcode,
  output logic [PC_W-1:0] pc,
  output logic [2:0]      state,
  output logic            ir_load,
  output logic            alu_src_imm,
  output logic            imm_s_type,
  output logic            reg_wrenable,
  output logic            mem_wrenable,
  output logic            mem_to_reg,
  output logic            busy,
  output logic            halted,
  output logic            illegal,
  output logic [15:0]     retired
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    C_R = 2'd0,
    C_I = 2'd1,
    C_S = 2'd2,
    C_L = 2'd3
  } cls_t;

  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;
  localparam logic [6:0] OP_S = 7'b0100011;
  localparam logic [6:0] OP_L = 7'b0000011;

  localparam int WW = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;
  localparam logic [WW-1:0] WAIT_LAST = WW'(MEM_WAIT - 1);
  localparam logic [PC_W-1:0] PC_STOP = PC_W'(PC_LAST);

  state_t          state_q, state_d;
  cls_t            cls_q, cls_d, dec_cls;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     ret_q, ret_d;
  logic [WW-1:0]   wait_q, wait_d;
  logic            ill_q, ill_d;
  logic            dec_ok;
  logic            retire;
  logic            step_go;

`ifdef SEQ_STEP_EN
  logic step_q;

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) step_q <= 1'b0;
    else          step_q <= step;
  end

  assign step_go = step & ~step_q;
`else
  assign step_go = 1'b0;
`endif

  always_comb begin
    dec_cls = C_R;
    dec_ok  = 1'b1;
    unique case (1'b1)
      (opcode == OP_R): dec_cls = C_R;
      (opcode == OP_I): dec_cls = C_I;
      (opcode == OP_S): dec_cls = C_S;
      (opcode == OP_L): dec_cls = C_L;
      default:          dec_ok  = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    pc_d    = pc_q;
    ret_d   = ret_q;
    wait_d  = wait_q;
    ill_d   = ill_q;
    retire  = 1'b0;
    case (state_q)
      S_IDLE:   if (run || step_go) state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        if (!dec_ok) begin
          state_d = S_HALT;
          ill_d   = 1'b1;
        end else begin
          cls_d   = dec_cls;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        wait_d  = '0;
        state_d = (cls_q == C_S || cls_q == C_L) ? S_MEM : S_WB;
      end
      S_MEM: begin
        if (cls_q == C_L) begin
          if (wait_q == WAIT_LAST) state_d = S_WB;
          else                     wait_d  = wait_q + 1'b1;
        end else begin
          retire = 1'b1;
        end
      end
      S_WB:     retire = 1'b1;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IDLE;
    endcase
    // pc stops at PC_LAST, so it never wraps
    if (retire) begin
      pc_d  = pc_q + 1'b1;
      ret_d = ret_q + 1'b1;
      if (pc_d == PC_STOP) state_d = S_HALT;
      else if (run)        state_d = S_FETCH;
      else                 state_d = S_IDLE;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cls_q   <= C_R;
      pc_q    <= '0;
      ret_q   <= '0;
      wait_q  <= '0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      pc_q    <= pc_d;
      ret_q   <= ret_d;
      wait_q  <= wait_d;
      ill_q   <= ill_d;
    end
  end

  logic in_xmw;

  assign in_xmw = (state_q == S_EXEC) || (state_q == S_MEM) ||
                  (state_q == S_WB);

  assign pc           = pc_q;
  assign state        = state_q;
  assign retired      = ret_q;
  assign illegal      = ill_q;
  assign ir_load      = (state_q == S_FETCH);
  assign reg_wrenable = (state_q == S_WB);
  assign mem_wrenable = (state_q == S_MEM) && (cls_q == C_S);
  assign mem_to_reg   = ((state_q == S_MEM) || (state_q == S_WB)) &&
                        (cls_q == C_L);
  assign alu_src_imm  = in_xmw && (cls_q != C_R);
  assign imm_s_type   = in_xmw && (cls_q == C_S);
  assign busy         = (state_q == S_FETCH) || (state_q == S_DECODE) ||
                        in_xmw;
  assign halted       = (state_q == S_HALT);

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer.
// Covers program run, illegal op, run drop, reset abort, load wait, step.
module tb_cpu_sequencer;

  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;
  localparam logic [6:0] OP_S = 7'b0100011;
  localparam logic [6:0] OP_L = 7'b0000011;

  logic CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  logic        reset_n, run, run_3, step, step_3;
  logic [6:0]  opcode, opcode_3;
  logic [6:0]  rom [32];

  logic [4:0]  pc, pc_3;
  logic [2:0]  state, state_3;
  logic        ir_load, alu_src_imm, imm_s_type, reg_wrenable;
  logic        mem_wrenable, mem_to_reg, busy, halted, illegal;
  logic        ir_load_3, alu_src_imm_3, imm_s_type_3, reg_wrenable_3;
  logic        mem_wrenable_3, mem_to_reg_3, busy_3, halted_3, illegal_3;
  logic [15:0] retired, retired_3;

  always_comb opcode = rom[pc];

  cpu_sequencer #(.PC_W(5), .PC_LAST(8), .MEM_WAIT(1)) u_dut (
    .CLOCK_50    (CLOCK_50),
    .reset_n     (reset_n),
    .run         (run),
`ifdef SEQ_STEP_EN
    .step        (step),
`endif
    .opcode      (opcode),
    .pc          (pc),
    .state       (state),
    .ir_load     (ir_load),
    .alu_src_imm (alu_src_imm),
    .imm_s_type  (imm_s_type),
    .reg_wrenable(reg_wrenable),
    .mem_wrenable(mem_wrenable),
    .mem_to_reg  (mem_to_reg),
    .busy        (busy),
    .halted      (halted),
    .illegal     (illegal),
    .retired     (retired)
  );

  cpu_sequencer #(.PC_W(5), .PC_LAST(8), .MEM_WAIT(3)) u_dut_3 (
    .CLOCK_50    (CLOCK_50),
    .reset_n     (reset_n),
    .run         (run_3),
`ifdef SEQ_STEP_EN
    .step        (step_3),
`endif
    .opcode      (opcode_3),
    .pc          (pc_3),
    .state       (state_3),
    .ir_load     (ir_load_3),
    .alu_src_imm (alu_src_imm_3),
    .imm_s_type  (imm_s_type_3),
    .reg_wrenable(reg_wrenable_3),
    .mem_wrenable(mem_wrenable_3),
    .mem_to_reg  (mem_to_reg_3),
    .busy        (busy_3),
    .halted      (halted_3),
    .illegal     (illegal_3),
    .retired     (retired_3)
  );

  int checks = 0;
  int errors = 0;
  int n_reg = 0, n_mem = 0, n_ir = 0, n_ld = 0, n_both = 0;

  always @(negedge CLOCK_50) begin
    if (reg_wrenable) n_reg++;
    if (mem_wrenable) n_mem++;
    if (ir_load) n_ir++;
    if (reg_wrenable && mem_to_reg) n_ld++;
    if (reg_wrenable && mem_wrenable) n_both++;
    if (reg_wrenable_3 && mem_wrenable_3) n_both++;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic do_reset;
    reset_n = 1'b0;
    run     = 1'b0;
    run_3   = 1'b0;
    step    = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  int cyc, b_reg, b_mem, b_ir, b_ld, lat, mem_at, wb_at;

  initial begin
    for (int i = 0; i < 32; i++) rom[i] = OP_R;
    opcode_3 = OP_L;
    step_3   = 1'b0;
    reset_n  = 1'b1;
    run      = 1'b0;
    run_3    = 1'b0;
    step     = 1'b0;

    #3 reset_n = 1'b0;
    #1;
    chk("rst_state", 32'(state), 0);
    chk("rst_pc", 32'(pc), 0);
    chk("rst_ret", 32'(retired), 0);
    chk("rst_outs", 32'({ir_load, reg_wrenable, mem_wrenable,
        mem_to_reg, alu_src_imm, imm_s_type, busy, halted, illegal}), 0);
    chk("rst_outs3", 32'({state_3, pc_3, retired_3, ir_load_3,
        reg_wrenable_3, mem_wrenable_3, mem_to_reg_3, alu_src_imm_3,
        imm_s_type_3, busy_3, halted_3, illegal_3}), 0);
    tick();
    tick();
    reset_n = 1'b1;

    // full program R,I,S,L,R,I,S,R up to PC_LAST
    rom[0] = OP_R; rom[1] = OP_I; rom[2] = OP_S; rom[3] = OP_L;
    rom[4] = OP_R; rom[5] = OP_I; rom[6] = OP_S; rom[7] = OP_R;
    b_reg = n_reg; b_mem = n_mem; b_ir = n_ir; b_ld = n_ld;
    cyc = 0;
    run = 1'b1;
    for (int k = 0; k < 100 && !halted; k++) begin
      tick();
      if (busy) cyc++;
    end
    chk("prog_halted", 32'(halted), 1);
    chk("prog_cycles", 32'(cyc), 33);
    chk("prog_pc", 32'(pc), 8);
    chk("prog_retired", 32'(retired), 8);
    chk("prog_regwr", 32'(n_reg - b_reg), 6);
    chk("prog_memwr", 32'(n_mem - b_mem), 2);
    chk("prog_irload", 32'(n_ir - b_ir), 8);
    chk("prog_ldwb", 32'(n_ld - b_ld), 1);
    tick();
    tick();
    chk("halt_absorb", 32'(state), 6);

    // illegal opcode at pc 0
    do_reset();
    chk("ill_clear", 32'(illegal), 0);
    rom[0] = 7'h7F;
    b_reg = n_reg; b_mem = n_mem;
    run = 1'b1;
    tick();
    chk("ill_fetch", 32'(state), 1);
    tick();
    chk("ill_decode", 32'(state), 2);
    tick();
    chk("ill_halt", 32'(state), 6);
    chk("ill_flag", 32'(illegal), 1);
    chk("ill_pc", 32'(pc), 0);
    chk("ill_ret", 32'(retired), 0);
    chk("ill_strobes", 32'((n_reg - b_reg) + (n_mem - b_mem)), 0);

    // run dropped during EXEC of a load
    do_reset();
    rom[0] = OP_L;
    run = 1'b1;
    tick();
    tick();
    tick();
    chk("ld_exec", 32'(state), 3);
    chk("ld_imm", 32'({alu_src_imm, imm_s_type}), 32'b10);
    run = 1'b0;
    tick();
    chk("ld_mem", 32'({state, mem_to_reg}), 32'b1001);
    tick();
    chk("ld_wb", 32'({state, reg_wrenable, mem_to_reg}), 32'b10111);
    tick();
    chk("ld_idle", 32'(state), 0);
    chk("ld_pc", 32'(pc), 1);
    chk("ld_busy", 32'(busy), 0);
    chk("ld_ret", 32'(retired), 1);
    tick();
    chk("ld_stay", 32'(state), 0);

    // reset during MEM of a store
    do_reset();
    rom[0] = OP_S;
    run = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    chk("st_mem", 32'({state, mem_wrenable, imm_s_type}), 32'b10011);
    reset_n = 1'b0;
    #1;
    chk("st_abort_wr", 32'(mem_wrenable), 0);
    chk("st_abort_st", 32'(state), 0);
    chk("st_abort_pc", 32'({pc, retired}), 0);
    tick();
    reset_n = 1'b1;
    run = 1'b0;

    // single load with MEM_WAIT=3
    do_reset();
    run_3 = 1'b1;
    tick();
    run_3 = 1'b0;
    lat = 0; mem_at = -1; wb_at = -1;
    for (int k = 0; k < 50; k++) begin
      if (!busy_3) break;
      lat++;
      if (state_3 == 3'd4 && mem_at < 0) mem_at = k;
      if (state_3 == 3'd5) wb_at = k;
      tick();
    end
    chk("w3_latency", 32'(lat), 7);
    chk("w3_wb_gap", 32'(wb_at - mem_at), 3);
    chk("w3_pc", 32'(pc_3), 1);

`ifdef SEQ_STEP_EN
    // single-step: second edge mid-instruction is ignored
    do_reset();
    for (int i = 0; i < 8; i++) rom[i] = OP_R;
    step = 1'b1;
    tick();
    chk("stp_fetch", 32'(state), 1);
    step = 1'b0;
    tick();
    step = 1'b1;
    tick();
    step = 1'b0;
    tick();
    tick();
    tick();
    chk("stp_idle", 32'(state), 0);
    chk("stp_pc1", 32'(pc), 1);
    step = 1'b1;
    tick();
    chk("stp_fetch2", 32'(state), 1);
    step = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    chk("stp_idle2", 32'(state), 0);
    chk("stp_pc2", 32'({pc, retired}), 32'({5'd2, 16'd2}));
`endif

    chk("strobe_excl", 32'(n_both), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
